// File: rtl/dac8568_ctrl.sv
// dac8568_ctrl: command sequencer in front of the DAC8568 serial writer.
// Runs the power-on init (software reset, internal reference on, power up A-H),
// then keeps an 8-entry channel value bank written by the host and sends one
// write-and-update command per pending channel, granted round-robin.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   wr_en_i      host write strobe (one cycle)
//   wr_ch_i      target channel 0..7 (A..H)
//   wr_val_i     16-bit channel code
//   reinit_i     one-cycle pulse, reruns init at the next idle point
//   dac_over_i   writer completion pulse
//   dac_start_o  one-cycle start pulse to the writer
//   dac_data_o   32-bit command word, held until completion or timeout
//   busy_o       high whenever not idle
//   init_done_o  high once the init sequence has completed
//   err_o        sticky writer timeout flag
//   pend_o       per-channel pending flags
module dac8568_ctrl #(
  parameter int unsigned INIT_DLY = 100,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] REF_CMD  = 32'h08000001,
  parameter logic [31:0] PWR_CMD  = 32'h040000FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en_i,
  input  logic [2:0]  wr_ch_i,
  input  logic [15:0] wr_val_i,
  input  logic        reinit_i,
  input  logic        dac_over_i,
  output logic        dac_start_o,
  output logic [31:0] dac_data_o,
  output logic        busy_o,
  output logic        init_done_o,
  output logic        err_o,
  output logic [7:0]  pend_o
);

  typedef enum logic [2:0] {
    StDelay, StInitIssue, StInitWait, StIdle, StIssue, StWait
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  grant_q, grant_d;
  logic [7:0]  pend_q, pend_d;
  logic [15:0] val_q [8];
  logic        start_q, start_d;
  logic [31:0] data_q, data_d;
  logic        init_done_q, init_done_d;
  logic        err_q, err_d;
  logic        reinit_q, reinit_d;

  logic [31:0] init_word;
  logic [2:0]  rr_grant;
  logic [2:0]  rr_cand;
  logic        rr_found;
  logic        timed_out;

  always_comb begin
    unique case (idx_q)
      2'd0:    init_word = 32'h07000000;
      2'd1:    init_word = REF_CMD;
      default: init_word = PWR_CMD;
    endcase
  end

  // Scan ptr+1 .. ptr+8 (mod 8) so the last-served channel has lowest priority.
  always_comb begin
    rr_grant = ptr_q;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int i = 1; i <= 8; i++) begin
      rr_cand = ptr_q + 3'(i);
      if (!rr_found && pend_q[rr_cand]) begin
        rr_grant = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  // A completion arriving in the expiry cycle counts as success.
  assign timed_out = !dac_over_i && (cnt_q == 16'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    pend_d      = pend_q;
    start_d     = 1'b0;
    data_d      = data_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    reinit_d    = reinit_q | reinit_i;

    unique case (state_q)
      StDelay: begin
        if (cnt_q == 16'(INIT_DLY - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StInitIssue;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StInitIssue: begin
        data_d  = init_word;
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = StInitWait;
      end
      StInitWait: begin
        if (dac_over_i || timed_out) begin
          if (timed_out) err_d = 1'b1;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd2) begin
            init_done_d = 1'b1;
            state_d     = StIdle;
          end else begin
            state_d = StInitIssue;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StIdle: begin
        if (reinit_q) begin
          reinit_d    = reinit_i;
          init_done_d = 1'b0;
          idx_d       = '0;
          state_d     = StInitIssue;
        end else if (|pend_q) begin
          grant_d = rr_grant;
          state_d = StIssue;
        end
      end
      StIssue: begin
        data_d          = {4'h0, 4'h3, 1'b0, grant_q, val_q[grant_q], 4'h0};
        pend_d[grant_q] = 1'b0;
        ptr_d           = grant_q;
        start_d         = 1'b1;
        cnt_d           = '0;
        state_d         = StWait;
      end
      StWait: begin
        if (dac_over_i) begin
          state_d = StIdle;
        end else if (timed_out) begin
          err_d           = 1'b1;
          pend_d[grant_q] = 1'b1;
          state_d         = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A host write wins over the clear in the issue cycle.
    if (wr_en_i) pend_d[wr_ch_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StDelay;
      cnt_q       <= '0;
      idx_q       <= '0;
      ptr_q       <= 3'd7;
      grant_q     <= '0;
      pend_q      <= '0;
      start_q     <= 1'b0;
      data_q      <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      reinit_q    <= 1'b0;
      for (int i = 0; i < 8; i++) val_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      pend_q      <= pend_d;
      start_q     <= start_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      reinit_q    <= reinit_d;
      if (wr_en_i) val_q[wr_ch_i] <= wr_val_i;
    end
  end

  assign dac_start_o = start_q;
  assign dac_data_o  = data_q;
  assign busy_o      = (state_q != StIdle);
  assign init_done_o = init_done_q;
  assign err_o       = err_q;
  assign pend_o      = pend_q;

endmodule

// File: tb/tb_dac8568_ctrl.sv
// Scoreboard bench for dac8568_ctrl: expected command words are queued when
// stimulus is issued; a monitor pops and compares on every dac_start.
module tb_dac8568_ctrl;

  localparam int INIT_DLY = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_ch = '0;
  logic [15:0] wr_val = '0;
  logic        reinit = 1'b0;
  logic        dac_over = 1'b0;
  logic        dac_start;
  logic [31:0] dac_data;
  logic        busy;
  logic        init_done;
  logic        err;
  logic [7:0]  pend;

  dac8568_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (wr_en),
    .wr_ch_i    (wr_ch),
    .wr_val_i   (wr_val),
    .reinit_i   (reinit),
    .dac_over_i (dac_over),
    .dac_start_o(dac_start),
    .dac_data_o (dac_data),
    .busy_o     (busy),
    .init_done_o(init_done),
    .err_o      (err),
    .pend_o     (pend)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int n_checks = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int last_over = -1000;
  int start_cyc = 0;
  int n_starts = 0;
  bit first_after_rel = 1'b0;
  int over_delay = 67;
  logic [31:0] exp_q[$];

  // Reference model: pending set, value bank, last-served pointer.
  logic [7:0]  pend_m = '0;
  logic [15:0] val_m [8];
  int          ptr_m = 7;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    errors++;
    $display("FAIL %s: bound expired, got no event expected one (cycle %0d)", name, cyc);
  endtask

  task automatic model_write(input int ch, input logic [15:0] v);
    pend_m[ch] = 1'b1;
    val_m[ch]  = v;
  endtask

  // Drain all pending channels in round-robin order after the last served one.
  task automatic serve_all();
    while (pend_m != 0) begin
      for (int k = 1; k <= 8; k++) begin
        int g;
        g = (ptr_m + k) % 8;
        if (pend_m[g]) begin
          exp_q.push_back(32'h03000000 | (32'(g) << 20) | (32'(val_m[g]) << 4));
          pend_m[g] = 1'b0;
          ptr_m = g;
          break;
        end
      end
    end
  endtask

  task automatic push_init();
    exp_q.push_back(32'h07000000);
    exp_q.push_back(32'h08000001);
    exp_q.push_back(32'h040000FF);
  endtask

  // Call aligned #1 after a posedge; returns #1 after the capturing edge.
  task automatic wr(input int ch, input logic [15:0] v);
    wr_en  = 1'b1;
    wr_ch  = 3'(ch);
    wr_val = v;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int bound);
    int t = 0;
    while (n_starts < n && t < bound) begin
      @(posedge clk);
      t++;
    end
    if (n_starts < n) fail("wait_start");
  endtask

  task automatic wait_quiet(input int bound);
    int q = 0;
    int t = 0;
    while (q < 4 && t < bound) begin
      @(negedge clk);
      t++;
      if (!busy && exp_q.size() == 0) q++;
      else q = 0;
    end
    if (q < 4) fail("wait_quiet");
  endtask

  // Monitor: every start pops one expected command.
  always @(negedge clk) begin
    if (dac_over) last_over = cyc;
    if (reset && dac_start) begin
      n_starts++;
      if (first_after_rel) begin
        check("init_delay", {31'b0, (cyc - rel_cyc) >= INIT_DLY}, 32'd1);
        first_after_rel = 1'b0;
      end
      check("start_gap", {31'b0, (cyc - last_over) >= 2}, 32'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        errors++;
        $display("FAIL cmd_unexpected: got %h expected no start", dac_data);
      end else begin
        check("cmd", dac_data, exp_q.pop_front());
      end
      start_cyc = cyc;
    end
  end

  // Writer model: answers over_delay cycles after start (0 = never).
  int          w_d;
  logic [31:0] w_word;
  bit          w_abort;
  initial begin
    forever begin
      @(negedge clk);
      if (reset && dac_start) begin
        w_d = over_delay;
        w_word = dac_data;
        if (w_d > 0) begin
          w_abort = 1'b0;
          for (int i = 0; i < w_d; i++) begin
            @(posedge clk);
            if (!reset) w_abort = 1'b1;
          end
          if (!w_abort) begin
            #1;
            check("data_stable", dac_data, w_word);
            dac_over = 1'b1;
            @(posedge clk);
            #1 dac_over = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    fail("watchdog");
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, ch, nw, s, t;
    logic [15:0] v, a;
    for (int i = 0; i < 8; i++) val_m[i] = '0;

    // Reset state
    #3;
    check("rst_start", {31'b0, dac_start}, 32'd0);
    check("rst_data", dac_data, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_init_done", {31'b0, init_done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_pend", {24'b0, pend}, 32'd0);

    // Power-up init, with a channel 3 write landing mid-init
    @(posedge clk);
    #3 reset = 1'b1;
    rel_cyc = cyc;
    first_after_rel = 1'b1;
    base = n_starts;
    push_init();
    repeat (130) @(posedge clk);
    #1;
    model_write(3, 16'h8000);
    serve_all();
    wr(3, 16'h8000);
    check("pend3_held", {31'b0, pend[3]}, 32'd1);
    check("init_not_done", {31'b0, init_done}, 32'd0);
    wait_starts(base + 4, 1500);
    #1 check("pend3_cleared", {31'b0, pend[3]}, 32'd0);
    wait_quiet(500);
    check("init_done", {31'b0, init_done}, 32'd1);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("no_err", {31'b0, err}, 32'd0);

    // Round robin from ptr=7: 0,5,7 then a repeat of 0 goes last
    @(posedge clk);
    #1;
    model_write(7, 16'h1111);
    serve_all();
    base = n_starts;
    wr(7, 16'h1111);
    wait_starts(base + 1, 20);
    #1;
    model_write(0, 16'hA0A0); wr(0, 16'hA0A0);
    model_write(5, 16'h5A5A); wr(5, 16'h5A5A);
    model_write(7, 16'h7777); wr(7, 16'h7777);
    serve_all();
    wait_starts(base + 2, 200);
    #1;
    model_write(0, 16'h0BB0);
    wr(0, 16'h0BB0);
    serve_all();
    wait_quiet(1000);
    check("rr_pend_empty", {24'b0, pend}, 32'd0);

    // Write to channel 2 in the same cycle the issue clears pend[2]
    @(posedge clk);
    #1;
    a = 16'($urandom);
    model_write(2, a);
    serve_all();
    base = n_starts;
    wr(2, a);
    @(posedge clk);
    #1;
    model_write(2, 16'h1234);
    serve_all();
    wr(2, 16'h1234);
    check("collide_start_now", {31'b0, dac_start}, 32'd1);
    check("collide_pend_kept", {31'b0, pend[2]}, 32'd1);
    wait_quiet(1000);

    // Randomized batches: one command in flight, more writes land meanwhile
    for (int b = 0; b < 6; b++) begin
      ch = $urandom_range(0, 7);
      v = 16'($urandom);
      @(posedge clk);
      #1;
      model_write(ch, v);
      serve_all();
      base = n_starts;
      wr(ch, v);
      wait_starts(base + 1, 20);
      repeat (2) @(posedge clk);
      #1;
      nw = $urandom_range(1, 6);
      for (int j = 0; j < nw; j++) begin
        ch = $urandom_range(0, 7);
        v = 16'($urandom);
        model_write(ch, v);
        wr(ch, v);
      end
      serve_all();
      wait_quiet(2000);
    end

    // Completion in the expiry cycle counts as success
    over_delay = 255;
    @(posedge clk);
    #1;
    model_write(6, 16'hCAFE);
    serve_all();
    wr(6, 16'hCAFE);
    wait_quiet(1000);
    check("expiry_over_ok", {31'b0, err}, 32'd0);
    check("expiry_pend", {24'b0, pend}, 32'd0);

    // Writer never answers: timeout, err, pend restored, retry succeeds
    over_delay = 0;
    @(posedge clk);
    #1;
    model_write(4, 16'h4444);
    serve_all();
    exp_q.push_back(32'h03444440);
    base = n_starts;
    wr(4, 16'h4444);
    wait_starts(base + 1, 20);
    s = start_cyc;
    t = 0;
    while (!err && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!err) fail("timeout_err");
    check("timeout_len", 32'(cyc - s), 32'd256);
    check("timeout_idle", {31'b0, busy}, 32'd0);
    check("timeout_pend", {31'b0, pend[4]}, 32'd1);
    over_delay = 67;
    wait_quiet(1000);
    check("err_sticky", {31'b0, err}, 32'd1);
    check("retry_pend", {24'b0, pend}, 32'd0);

    // Reinit while busy is latched and replays init after the command
    @(posedge clk);
    #1;
    model_write(1, 16'h0101);
    serve_all();
    push_init();
    wr(1, 16'h0101);
    reinit = 1'b1;
    @(posedge clk);
    #1 reinit = 1'b0;
    repeat (90) @(posedge clk);
    #1 check("reinit_clears_done", {31'b0, init_done}, 32'd0);
    wait_quiet(2000);
    check("reinit_done", {31'b0, init_done}, 32'd1);

    // Reset in the middle of a command wait
    @(posedge clk);
    #1;
    model_write(5, 16'h5555);
    serve_all();
    base = n_starts;
    wr(5, 16'h5555);
    wait_starts(base + 1, 20);
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_start", {31'b0, dac_start}, 32'd0);
    check("mid_rst_data", dac_data, 32'd0);
    check("mid_rst_pend", {24'b0, pend}, 32'd0);
    check("mid_rst_init_done", {31'b0, init_done}, 32'd0);
    check("mid_rst_err", {31'b0, err}, 32'd0);
    pend_m = '0;
    ptr_m = 7;
    for (int i = 0; i < 8; i++) val_m[i] = '0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    rel_cyc = cyc;
    first_after_rel = 1'b1;
    base = n_starts;
    push_init();
    wait_quiet(2000);
    check("reinit_after_rst_starts", 32'(n_starts - base), 32'd3);
    check("rst_init_done_again", {31'b0, init_done}, 32'd1);
    check("exp_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
